// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, framebuffer geometry and arbiter types for the VRAM arbiter.
package vga_pkg;

  localparam int unsigned H_ACTIVE_DFLT = 640;
  localparam int unsigned V_ACTIVE_DFLT = 480;
  localparam int unsigned H_TOTAL_DFLT  = 800;
  localparam int unsigned V_TOTAL_DFLT  = 525;

  localparam int unsigned CELL_COLS  = 80;
  localparam int unsigned CELL_ROWS  = 60;
  localparam int unsigned CELL_COUNT = CELL_COLS * CELL_ROWS;

  typedef logic [12:0] addr_t;

  typedef enum logic [1:0] {
    ArbIdle = 2'd0,
    ArbDisp = 2'd1,
    ArbHost = 2'd2
  } arb_state_e;

  typedef struct packed {
    addr_t      addr;
    logic [7:0] data;
  } wr_entry_t;

  function automatic addr_t cell_addr(input logic [6:0] row, input logic [6:0] col);
    return addr_t'(row) * addr_t'(CELL_COLS) + addr_t'(col);
  endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// Host write channel plus single-port VRAM bus; slave is the arbiter, master is host and RAM.
interface vram_arbiter_if;
  import vga_pkg::*;

  logic       wr_valid;
  logic       wr_ready;
  addr_t      wr_addr;
  logic [7:0] wr_data;
  addr_t      ram_addr;
  logic       ram_we;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;

  modport slave (
    input  wr_valid, wr_addr, wr_data, ram_rdata,
    output wr_ready, ram_addr, ram_we, ram_wdata
  );

  modport master (
    output wr_valid, wr_addr, wr_data, ram_rdata,
    input  wr_ready, ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/vram_wr_fifo.sv
// Synchronous first-word-fall-through FIFO for queued host writes.
module vram_wr_fifo
  import vga_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  wr_entry_t data_i,
  input  logic      pop_i,
  output wr_entry_t data_o,
  output logic      empty_o,
  output logic      full_o
);

  localparam int unsigned Aw       = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [Aw-1:0] LastIdx  = Aw'(Depth - 1);
  localparam logic [Aw-1:0] PtrOne   = Aw'(1);
  localparam logic [Aw:0]   CntOne   = (Aw+1)'(1);
  localparam logic [Aw:0]   DepthCnt = (Aw+1)'(Depth);

  logic [Aw-1:0] wr_ptr_q, rd_ptr_q;
  logic [Aw:0]   cnt_q;
  wr_entry_t     mem_q [Depth];
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == DepthCnt);
  assign do_pop  = pop_i && !empty_o;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= (wr_ptr_q == LastIdx) ? '0 : wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_q <= (rd_ptr_q == LastIdx) ? '0 : rd_ptr_q + PtrOne;
      if (do_push && !do_pop)      cnt_q <= cnt_q + CntOne;
      else if (do_pop && !do_push) cnt_q <= cnt_q - CntOne;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/vram_arbiter.sv
// VRAM arbiter: display cell fetches always win, queued host writes fill the idle cycles.
// Define VRAM_ARB_STATS_EN to add the wr_stall_cnt backpressure counter output.
module vram_arbiter
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = H_ACTIVE_DFLT,
  parameter int unsigned V_ACTIVE   = V_ACTIVE_DFLT,
  parameter int unsigned H_TOTAL    = H_TOTAL_DFLT,
  parameter int unsigned V_TOTAL    = V_TOTAL_DFLT,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [9:0]    x_axis,
  input  logic [9:0]    y_axis,
  vram_arbiter_if.slave bus,
  output logic [7:0]    pixel_data,
  output logic [1:0]    arb_state
`ifdef VRAM_ARB_STATS_EN
  ,
  output logic [15:0]   wr_stall_cnt
`endif
);

  localparam logic [9:0] HSlotLim  = 10'(H_ACTIVE - 8);
  localparam logic [9:0] VActW     = 10'(V_ACTIVE);
  localparam logic [9:0] HWrap     = 10'(H_TOTAL - 2);
  localparam logic [9:0] VLast     = 10'(V_TOTAL - 1);
  localparam addr_t      CellCount = addr_t'(CELL_COUNT);

  logic [9:0] y_next;
  logic       slot_cell, slot_line, slot;
  addr_t      slot_addr;

  // Decode on the current x/y so the registered RAM address lands on the slot cycle.
  always_comb begin
    y_next    = (y_axis == VLast) ? '0 : y_axis + 10'd1;
    slot_cell = (x_axis[2:0] == 3'd6) && (x_axis < HSlotLim) && (y_axis < VActW);
    slot_line = (x_axis == HWrap) && (y_next < VActW);
    slot      = slot_cell || slot_line;
    slot_addr = slot_line ? cell_addr(y_next[9:3], 7'd0)
                          : cell_addr(y_axis[9:3], x_axis[9:3] + 7'd1);
  end

  wr_entry_t wr_in, head;
  logic      fifo_empty, fifo_full, push, pop;

  assign wr_in        = '{addr: bus.wr_addr, data: bus.wr_data};
  assign bus.wr_ready = !fifo_full && !rst;
  assign push         = bus.wr_valid && bus.wr_ready;
  assign pop          = !slot && !fifo_empty;

  vram_wr_fifo #(
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .data_i (wr_in),
    .pop_i  (pop),
    .data_o (head),
    .empty_o(fifo_empty),
    .full_o (fifo_full)
  );

  arb_state_e state_q;
  addr_t      ram_addr_q;
  logic       ram_we_q, rd_pend_q;
  logic [7:0] ram_wdata_q, pixel_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ArbIdle;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      rd_pend_q   <= 1'b0;
      pixel_q     <= '0;
    end else begin
      // Read data returns one cycle after the DISP cycle.
      rd_pend_q <= (state_q == ArbDisp);
      if (rd_pend_q) pixel_q <= bus.ram_rdata;

      if (slot) begin
        state_q    <= ArbDisp;
        ram_addr_q <= slot_addr;
        ram_we_q   <= 1'b0;
      end else if (!fifo_empty) begin
        state_q  <= ArbHost;
        ram_we_q <= (head.addr < CellCount);
        if (head.addr < CellCount) begin
          ram_addr_q  <= head.addr;
          ram_wdata_q <= head.data;
        end
      end else begin
        state_q  <= ArbIdle;
        ram_we_q <= 1'b0;
      end
    end
  end

  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign pixel_data    = pixel_q;
  assign arb_state     = state_q;

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (bus.wr_valid && !bus.wr_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign wr_stall_cnt = stall_q;
`endif

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 Parameter V_ACTIVE, default 480: visible lines per frame.
REQ-003 Parameter H_TOTAL, default 800: pixel clocks per line, blanking included.
REQ-004 Parameter V_TOTAL, default 525: lines per frame, blanking included.
REQ-005 Parameter FIFO_DEPTH, default 4: host write FIFO entries, power of two.
REQ-006 clk  input  1  single clock, one pixel per cycle; rst  input  1  synchronous, active-high reset.
REQ-007 x_axis  input  10  current pixel column from VGA timing; y_axis  input  10  current line.
REQ-008 wr_valid  input  1; wr_ready  output  1; wr_addr  input  13; wr_data  input  8  host write channel.
REQ-009 ram_addr  output  13; ram_we  output  1; ram_wdata  output  8; ram_rdata  input  8  single-port VRAM, 1-cycle read latency.
REQ-010 pixel_data  output  8  colour of the current 8x8 cell; arb_state  output  2  FSM state for debug.

Function
REQ-011 Framebuffer is 80x60 cells; cell address SHALL be row*80 + col, where row = y>>3 and col = x>>3.
REQ-012 Display slot at x[2:0]==6 with x < H_ACTIVE-8 and y < V_ACTIVE: read cell (col+1, y>>3).
REQ-013 Display slot at x==H_TOTAL-2: read cell (0, yn>>3), where yn = (y==V_TOTAL-1) ? 0 : y+1; skip if yn >= V_ACTIVE.
REQ-014 pixel_data SHALL capture ram_rdata on the cycle after each display slot and hold it otherwise.
REQ-015 Display slots have absolute priority; a host write SHALL never delay or displace a display read.
REQ-016 Host writes use a FIFO_DEPTH-entry FIFO; wr_ready = !full, and a push occurs when wr_valid && wr_ready.
REQ-017 On any non-display cycle with the FIFO non-empty, pop the head: ram_we=1, ram_addr/ram_wdata = head entry.
REQ-018 Push and pop in the same cycle SHALL be legal when full: occupancy is unchanged and wr_ready stays 0 that cycle.
REQ-019 Write addresses >= 4800 SHALL be popped and discarded with ram_we=0.
REQ-020 FSM states: IDLE(0), DISP(1), HOST(2); state reflects the current-cycle RAM owner; DISP overrides HOST.
REQ-021 ram_addr, ram_we and ram_wdata SHALL be registered outputs; slot decode uses x and y one cycle early to compensate.
REQ-022 When idle, ram_we=0 and ram_addr holds its last value.

Reset
REQ-023 On rst: FIFO empty, wr_ready=0 during reset and 1 on the first cycle after, pixel_data=0, ram_we=0, ram_addr=0, ram_wdata=0, arb_state=IDLE.
REQ-024 Reset mid-write SHALL drop all queued FIFO entries; no partial write may be issued.

Configuration
REQ-025 With VRAM_ARB_STATS_EN defined, add output wr_stall_cnt[15:0]: counts cycles with wr_valid && !wr_ready, saturates at 0xFFFF, cleared by rst.
REQ-026 Without VRAM_ARB_STATS_EN, the port and its counter SHALL be absent.

Structure
REQ-027 Package vga_pkg holds the H/V timing constants, CELL_COLS=80, CELL_ROWS=60, the 13-bit address typedef and the arb_state enum.
REQ-028 The FIFO SHALL be the sub-module vram_wr_fifo (sync, first-word-fall-through, parameterised depth); the arbiter FSM and slot decode stay in vram_arbiter.

Verification
REQ-029 Reset: rst=1 for 3 cycles -> all outputs 0 and arb_state=IDLE; wr_ready=1 on the first cycle after release.
REQ-030 Slot decode: x=14, y=17 -> next cycle ram_addr=2*80+2=162, ram_we=0; pixel_data=ram_rdata one cycle after that.
REQ-031 Line wrap: x=798, y=524 -> fetch address 0; x=798, y=479 -> no fetch (yn=480).
REQ-032 Priority: wr_valid is held with addr 100, data 0x5A while x sweeps 0..15 -> writes occur only on non-slot cycles; no write at a display slot; RAM holds 0x5A.
REQ-033 Backpressure: 6 writes are pushed during active video with no free cycles -> wr_ready drops after 4; all 6 land in order; wr_stall_cnt is nonzero when VRAM_ARB_STATS_EN is defined.
REQ-034 Out-of-range and reset: a write to addr 5000 -> popped with ram_we=0; rst asserted with 3 entries queued -> none is written after release.
